// File: rtl/timer_master_seq.sv
// Avalon-MM master that programs, starts/stops, services and timestamps the interval timer.
// Optional build macro TIMER_SEQ_OVERRUN_EN adds the overrun_cnt output counting merged requests.
`timescale 1ns/1ps

module timer_master_seq #(
    parameter int unsigned TICK_W  = 32,
    parameter logic [3:0]  RUN_CTL = 4'b0111
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              stop_req,
    input  logic              stamp_req,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              irq,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       stamp_value,
    output logic              stamp_valid
`ifdef TIMER_SEQ_OVERRUN_EN
    ,
    output logic [7:0]        overrun_cnt
`endif
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, CLR_ST, SNAP_WR, RD_L, RD_H, CAP_H
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_cfg_pend;
    logic                r_stop_pend;
    logic                r_stamp_pend;
    logic [31:0]         r_period;
    logic [2:0]          r_address;
    logic                r_chipselect;
    logic                r_write_n;
    logic [15:0]         r_writedata;
    logic                r_busy;
    logic                r_tick;
    logic [TICK_W-1:0]   r_tick_count;
    logic [15:0]         r_stamp_lo;
    logic [31:0]         r_stamp_value;
    logic                r_stamp_valid;

    logic [31:0]         w_period;
    logic                w_start_cfg;
    logic                w_start_stop;
    logic                w_start_stamp;
    logic [2:0]          w_addr_nxt;
    logic                w_cs_nxt;
    logic                w_wn_nxt;
    logic [15:0]         w_wdata_nxt;

    // A cfg_start coinciding with the sequence start must supply the low half too.
    assign w_period = cfg_start ? cfg_period : r_period;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus the bus cycle that state will present once registered.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_cfg   = 1'b0;
        w_start_stop  = 1'b0;
        w_start_stamp = 1'b0;
        w_addr_nxt    = 3'd0;
        w_cs_nxt      = 1'b0;
        w_wn_nxt      = 1'b1;
        w_wdata_nxt   = 16'd0;

        case (r_state)
            IDLE: begin
                if (irq) begin
                    w_state_nxt = CLR_ST;
                end else if (r_cfg_pend) begin
                    w_state_nxt = WR_PL;
                    w_start_cfg = 1'b1;
                end else if (r_stop_pend) begin
                    w_state_nxt  = WR_STOP;
                    w_start_stop = 1'b1;
                end else if (r_stamp_pend) begin
                    w_state_nxt   = SNAP_WR;
                    w_start_stamp = 1'b1;
                end
            end
            WR_PL:   w_state_nxt = WR_PH;
            WR_PH:   w_state_nxt = WR_CTL;
            WR_CTL:  w_state_nxt = IDLE;
            WR_STOP: w_state_nxt = IDLE;
            CLR_ST:  w_state_nxt = IDLE;
            SNAP_WR: w_state_nxt = RD_L;
            RD_L:    w_state_nxt = RD_H;
            RD_H:    w_state_nxt = CAP_H;
            CAP_H:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            WR_PL:   begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = 3'd2; w_wdata_nxt = w_period[15:0]; end
            WR_PH:   begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = 3'd3; w_wdata_nxt = w_period[31:16]; end
            WR_CTL:  begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = 3'd1; w_wdata_nxt = 16'(RUN_CTL); end
            WR_STOP: begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = 3'd1; w_wdata_nxt = 16'h0008; end
            CLR_ST:  begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = 3'd0; end
            SNAP_WR: begin w_cs_nxt = 1'b1; w_wn_nxt = 1'b0; w_addr_nxt = 3'd4; end
            RD_L:    begin w_cs_nxt = 1'b1; w_addr_nxt = 3'd4; end
            RD_H:    begin w_cs_nxt = 1'b1; w_addr_nxt = 3'd5; end
            default: ;
        endcase
    end

    // Request flags, period latch and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cfg_pend   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_stamp_pend <= 1'b0;
            r_period     <= 32'd0;
            r_address    <= 3'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 16'd0;
            r_busy       <= 1'b0;
        end else begin
            r_cfg_pend   <= (r_cfg_pend   & ~w_start_cfg)   | cfg_start;
            r_stop_pend  <= (r_stop_pend  & ~w_start_stop)  | stop_req;
            r_stamp_pend <= (r_stamp_pend & ~w_start_stamp) | stamp_req;
            if (cfg_start) r_period <= cfg_period;
            r_address    <= w_addr_nxt;
            r_chipselect <= w_cs_nxt;
            r_write_n    <= w_wn_nxt;
            r_writedata  <= w_wdata_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    // Interrupt tick and timestamp capture; slave read data lags the address by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tick        <= 1'b0;
            r_tick_count  <= '0;
            r_stamp_lo    <= 16'd0;
            r_stamp_value <= 32'd0;
            r_stamp_valid <= 1'b0;
        end else begin
            r_tick        <= (r_state == CLR_ST);
            r_stamp_valid <= (r_state == CAP_H);
            if (r_state == CLR_ST) r_tick_count  <= r_tick_count + TICK_W'(1);
            if (r_state == RD_H)   r_stamp_lo    <= readdata;
            if (r_state == CAP_H)  r_stamp_value <= {readdata, r_stamp_lo};
        end
    end

`ifdef TIMER_SEQ_OVERRUN_EN
    logic [7:0] r_overrun_cnt;
    logic       w_merge;

    assign w_merge = (cfg_start & r_cfg_pend   & ~w_start_cfg)
                   | (stop_req  & r_stop_pend  & ~w_start_stop)
                   | (stamp_req & r_stamp_pend & ~w_start_stamp);

    always_ff @(posedge clk) begin
        if (!reset_n)                            r_overrun_cnt <= 8'd0;
        else if (w_merge && r_overrun_cnt != 8'hFF) r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

    assign address     = r_address;
    assign chipselect  = r_chipselect;
    assign write_n     = r_write_n;
    assign writedata   = r_writedata;
    assign busy        = r_busy;
    assign tick        = r_tick;
    assign tick_count  = r_tick_count;
    assign stamp_value = r_stamp_value;
    assign stamp_valid = r_stamp_valid;

endmodule

// File: tb/tb_timer_master_seq.sv
// Bench for timer_master_seq: directed scenarios, then random requests checked by a bus-level scoreboard.
`timescale 1ns/1ps

module tb_timer_master_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic        stop_req = 1'b0;
    logic        stamp_req = 1'b0;
    logic [15:0] readdata = 16'd0;
    logic        irq = 1'b0;
    logic        irq_fire = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        busy;
    logic        tick;
    logic [31:0] tick_count;
    logic [31:0] stamp_value;
    logic        stamp_valid;
`ifdef TIMER_SEQ_OVERRUN_EN
    logic [7:0]  overrun_cnt;
`endif

    timer_master_seq dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .stop_req(stop_req), .stamp_req(stamp_req), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .busy(busy), .tick(tick),
        .tick_count(tick_count), .stamp_value(stamp_value), .stamp_valid(stamp_valid)
`ifdef TIMER_SEQ_OVERRUN_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [2:0]  a;
        logic [15:0] d;
    } bus_t;

    bus_t        bq[$];
    int          cyc = 0;
    int          busy_cnt = 0;
    int          tick_seen = 0;
    int          stamp_seen = 0;
    logic [31:0] last_stamp = 32'd0;
    logic [15:0] rd_val [8];
    int          n_chk = 0;
    int          n_pass = 0;
    int          exp_ticks = 0;

    // Timer slave model: registered read data; a status write clears the timeout.
    always @(posedge clk) begin
        if (chipselect && write_n) readdata <= rd_val[address];
        if (chipselect && !write_n && address == 3'd0) irq <= 1'b0;
        else if (irq_fire)                             irq <= 1'b1;
    end

    always @(posedge clk) begin
        bus_t e;
        #1;
        cyc++;
        if (chipselect) begin
            e.cyc = cyc; e.wr = !write_n; e.a = address; e.d = writedata;
            bq.push_back(e);
        end
        if (busy) busy_cnt++;
        if (tick) tick_seen++;
        if (stamp_valid) begin
            stamp_seen++;
            last_stamp = stamp_value;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon();
        bq.delete();
        busy_cnt = 0; tick_seen = 0; stamp_seen = 0;
    endtask

    task automatic pulse(input logic c, input logic s, input logic st, input logic f, input logic [31:0] p);
        @(negedge clk);
        cfg_start = c; stop_req = s; stamp_req = st; irq_fire = f;
        if (c) cfg_period = p;
        @(negedge clk);
        cfg_start = 1'b0; stop_req = 1'b0; stamp_req = 1'b0; irq_fire = 1'b0;
    endtask

    function automatic logic [63:0] ent(input int i);
        if (i < bq.size()) return 64'({bq[i].wr, bq[i].a, bq[i].d});
        return '1;
    endfunction

    function automatic logic [63:0] ehdr(input int i);
        if (i < bq.size()) return 64'({bq[i].wr, bq[i].a});
        return '1;
    endfunction

    function automatic int ecyc(input int i);
        if (i < bq.size()) return bq[i].cyc;
        return -1000;
    endfunction

    function automatic int count_kind(input logic wr, input logic [2:0] a);
        int n = 0;
        foreach (bq[i]) if (bq[i].wr == wr && bq[i].a == a) n++;
        return n;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_bus"}, 64'({chipselect, write_n, address, writedata}), 64'({1'b0, 1'b1, 3'd0, 16'd0}));
        chk({tag, "_flags"}, 64'({busy, tick, stamp_valid}), 64'd0);
        chk({tag, "_tick_count"}, 64'(tick_count), 64'd0);
        chk({tag, "_stamp_value"}, 64'(stamp_value), 64'd0);
`ifdef TIMER_SEQ_OVERRUN_EN
        chk({tag, "_overrun"}, 64'(overrun_cnt), 64'd0);
`endif
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] last_period;
        logic [31:0] period_seen;
        int found, idx, prev_end, exp_stamps, rnd_ticks;
        int cfg_req, stop_req_c, stamp_req_c, cfg_last, stop_last, stamp_last;

        foreach (rd_val[k]) rd_val[k] = 16'(k);

        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;

        // Program period and start.
        clr_mon();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_5F8F);
        cycles(8);
        chk("cfg_n", 64'(bq.size()), 64'd3);
        chk("cfg_pl", ent(0), 64'({1'b1, 3'd2, 16'h5F8F}));
        chk("cfg_ph", ent(1), 64'({1'b1, 3'd3, 16'h0001}));
        chk("cfg_ctl", ent(2), 64'({1'b1, 3'd1, 16'h0007}));
        chk("cfg_consec", 64'(ecyc(2) - ecyc(0)), 64'd2);
        chk("cfg_busy", 64'(busy_cnt), 64'd3);

        // Single timeout service.
        clr_mon();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        cycles(8);
        exp_ticks++;
        chk("irq_n", 64'(bq.size()), 64'd1);
        chk("irq_clr", ent(0), 64'({1'b1, 3'd0, 16'd0}));
        chk("irq_tick", 64'(tick_seen), 64'd1);
        chk("irq_count", 64'(tick_count), 64'(exp_ticks));
        chk("irq_low", 64'(irq), 64'd0);

        // Timestamp.
        rd_val[4] = 16'h1234; rd_val[5] = 16'hABCD;
        clr_mon();
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycles(10);
        chk("st_n", 64'(bq.size()), 64'd3);
        chk("st_snap", ent(0), 64'({1'b1, 3'd4, 16'd0}));
        chk("st_rdl", ehdr(1), 64'({1'b0, 3'd4}));
        chk("st_rdh", ehdr(2), 64'({1'b0, 3'd5}));
        chk("st_consec", 64'(ecyc(2) - ecyc(0)), 64'd2);
        chk("st_valid_len", 64'(stamp_seen), 64'd1);
        chk("st_value", 64'(last_stamp), 64'hABCD_1234);

        // irq wins over a simultaneous cfg, no interleaving.
        p = $urandom;
        clr_mon();
        pulse(1'b1, 1'b0, 1'b0, 1'b1, p);
        cycles(12);
        exp_ticks++;
        chk("ic_n", 64'(bq.size()), 64'd4);
        chk("ic_clr", ent(0), 64'({1'b1, 3'd0, 16'd0}));
        chk("ic_pl", ent(1), 64'({1'b1, 3'd2, p[15:0]}));
        chk("ic_ph", ent(2), 64'({1'b1, 3'd3, p[31:16]}));
        chk("ic_ctl", ent(3), 64'({1'b1, 3'd1, 16'h0007}));
        chk("ic_gap", 64'(ecyc(1) - ecyc(0) >= 2), 64'd1);
        chk("ic_count", 64'(tick_count), 64'(exp_ticks));

        // Stop arriving mid-stamp waits for CAP_H and one idle cycle.
        rd_val[4] = 16'($urandom); rd_val[5] = 16'($urandom);
        clr_mon();
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycles(1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycles(10);
        chk("ss_n", 64'(bq.size()), 64'd4);
        chk("ss_rdh", ehdr(2), 64'({1'b0, 3'd5}));
        chk("ss_stop", ent(3), 64'({1'b1, 3'd1, 16'h0008}));
        chk("ss_gap", 64'(ecyc(3) - ecyc(2)), 64'd3);
        chk("ss_value", 64'(last_stamp), 64'({rd_val[5], rd_val[4]}));

`ifdef TIMER_SEQ_OVERRUN_EN
        // Three stamp requests during a cfg sequence collapse to one.
        clr_mon();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("ov_busy", 64'(busy), 64'd1);
        stamp_req = 1'b1;
        repeat (3) @(negedge clk);
        stamp_req = 1'b0;
        cycles(14);
        chk("ov_stamps", 64'(count_kind(1'b0, 3'd5)), 64'd1);
        chk("ov_cnt", 64'(overrun_cnt), 64'd2);
`endif

        // Reset while in RD_L aborts the sequence.
        clr_mon();
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        found = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (chipselect && write_n && address == 3'd4) begin
                found = 1;
                break;
            end
        end
        chk("rdl_seen", 64'(found), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        check_reset("rst_rdl");
        @(negedge clk);
        reset_n = 1'b1;
        exp_ticks = 0;
        clr_mon();
        cycles(10);
        chk("rst_quiet", 64'(bq.size()), 64'd0);

        // Random traffic; scoreboard parses the bus stream into sequences.
        rd_val[4] = 16'($urandom); rd_val[5] = 16'($urandom);
        cfg_req = -1; stop_req_c = -1; stamp_req_c = -1;
        last_period = 32'd0;
        clr_mon();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            cfg_start = ($urandom_range(15) == 0);
            stop_req  = ($urandom_range(15) == 0);
            stamp_req = ($urandom_range(15) == 0);
            irq_fire  = ($urandom_range(23) == 0);
            if (cfg_start) begin
                cfg_period  = $urandom;
                last_period = cfg_period;
                cfg_req     = cyc + 1;
            end
            if (stop_req)  stop_req_c  = cyc + 1;
            if (stamp_req) stamp_req_c = cyc + 1;
        end
        @(negedge clk);
        cfg_start = 1'b0; stop_req = 1'b0; stamp_req = 1'b0; irq_fire = 1'b0;
        cycles(40);

        idx = 0; prev_end = -100; exp_stamps = 0; rnd_ticks = 0;
        cfg_last = -1; stop_last = -1; stamp_last = -1; period_seen = 32'd0;
        while (idx < bq.size()) begin
            chk("r_gap", 64'(bq[idx].cyc - prev_end >= 2), 64'd1);
            if (bq[idx].wr && bq[idx].a == 3'd0) begin
                chk("r_clr_data", 64'(bq[idx].d), 64'd0);
                rnd_ticks++;
                prev_end = bq[idx].cyc;
                idx += 1;
            end else if (bq[idx].wr && bq[idx].a == 3'd2) begin
                chk("r_cfg_shape", 64'({ehdr(idx + 1), ent(idx + 2), 32'(ecyc(idx + 2) - ecyc(idx))}),
                    64'({64'({1'b1, 3'd3}), 64'({1'b1, 3'd1, 16'h0007}), 32'd2}));
                period_seen = {bq[idx + 1 < bq.size() ? idx + 1 : idx].d, bq[idx].d};
                cfg_last = bq[idx].cyc;
                prev_end = ecyc(idx + 2);
                idx += 3;
            end else if (bq[idx].wr && bq[idx].a == 3'd1 && bq[idx].d == 16'h0008) begin
                stop_last = bq[idx].cyc;
                prev_end = bq[idx].cyc;
                idx += 1;
            end else if (bq[idx].wr && bq[idx].a == 3'd4) begin
                chk("r_stamp_shape", 64'({ehdr(idx + 1), ehdr(idx + 2), 32'(ecyc(idx + 2) - ecyc(idx))}),
                    64'({64'({1'b0, 3'd4}), 64'({1'b0, 3'd5}), 32'd2}));
                exp_stamps++;
                stamp_last = bq[idx].cyc;
                prev_end = ecyc(idx + 2) + 1;
                idx += 3;
            end else begin
                chk("r_seq_kind", ent(idx), 64'hFFFF_FFFF_FFFF_FFFF);
                idx += 1;
            end
        end
        exp_ticks += rnd_ticks;
        chk("r_tick_count", 64'(tick_count), 64'(exp_ticks));
        chk("r_tick_pulses", 64'(tick_seen), 64'(rnd_ticks));
        chk("r_stamp_pulses", 64'(stamp_seen), 64'(exp_stamps));
        if (exp_stamps > 0) chk("r_stamp_value", 64'(last_stamp), 64'({rd_val[5], rd_val[4]}));
        if (cfg_req >= 0) begin
            chk("r_cfg_served", 64'(cfg_last > cfg_req), 64'd1);
            chk("r_period", 64'(period_seen), 64'(last_period));
        end
        if (stop_req_c >= 0)  chk("r_stop_served", 64'(stop_last > stop_req_c), 64'd1);
        if (stamp_req_c >= 0) chk("r_stamp_served", 64'(stamp_last > stamp_req_c), 64'd1);
        chk("r_irq_drained", 64'(irq), 64'd0);
        chk("r_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_master_seq.md
Name: timer_master_seq

Overview:
Avalon-MM master that drives the 16-bit timer slave port (status/control/period/snapshot map) on behalf of the metering datapath. It programs the period, starts and stops the timer, services the timeout interrupt, and reads 32-bit counter snapshots as timestamps. One transaction is issued at a time. Sits between the metering control FSM and the interval timer, with no CPU involvement.

Parameters:
TICK_W, 32, width of the serviced-interrupt tick counter
RUN_CTL, 4'b0111, control word written on start (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
cfg_start  in  1  pulse: program cfg_period and start timer
cfg_period  in  32  period value, sampled when cfg_start is accepted
stop_req  in  1  pulse: stop timer
stamp_req  in  1  pulse: capture timestamp
address  out  3  master address to timer slave
chipselect  out  1  slave select
write_n  out  1  active-low write
writedata  out  16  write data
readdata  in  16  slave read data, registered in slave (valid 1 cycle after address)
irq  in  1  timer interrupt, level
busy  out  1  FSM not in IDLE
tick  out  1  1-cycle pulse per serviced interrupt
tick_count  out  TICK_W  serviced interrupt count, wraps
stamp_value  out  32  last snapshot {high,low}
stamp_valid  out  1  1-cycle pulse when stamp_value updates

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; chipselect=0, write_n=1, address=0, writedata=0, busy=0, tick=0, tick_count=0, stamp_value=0, stamp_valid=0; all pending flags and the period latch are cleared.
- Request capture: cfg_start, stop_req and stamp_req each set a one-deep pending flag. A flag clears when its sequence starts. A repeat request while its flag is set is merged. cfg_period is latched on every cfg_start pulse; the latest value wins.
- Bus outputs are registered. Each write is exactly one cycle with chipselect=1 and write_n=0. Reads are one cycle with chipselect=1, write_n=1 and the address held; data is captured on the following cycle. No waitrequest.
- States and the bus cycle each issues:
  - IDLE: no bus access.
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_CTL: addr 1, data RUN_CTL.
  - WR_STOP: addr 1, data 4'b1000.
  - CLR_ST: addr 0, data 0.
  - SNAP_WR: addr 4, data 0.
  - RD_L: addr 4, read.
  - RD_H: addr 5, read; low half captured from readdata this cycle.
  - CAP_H: capture high half; no bus access.
- Arbitration in IDLE uses fixed priority: irq > cfg > stop > stamp.
  - irq: IDLE->CLR_ST->IDLE. tick pulses and tick_count increments in the cycle after CLR_ST.
  - cfg: IDLE->WR_PL->WR_PH->WR_CTL->IDLE.
  - stop: IDLE->WR_STOP->IDLE.
  - stamp: IDLE->SNAP_WR->RD_L->RD_H->CAP_H->IDLE. stamp_value={readdata,low} and stamp_valid pulses in the cycle after CAP_H.
- Sequences are atomic. An irq arriving mid-sequence waits for IDLE. irq is level-sensitive, so it is not lost.
- The FSM spends at least one cycle in IDLE between sequences. This lets irq deassert after CLR_ST, so one timeout gives exactly one tick.
- busy=1 in every non-IDLE state.
- tick_count wraps from all-ones to 0.
- Reset mid-sequence aborts the sequence; no further bus cycles are issued.

Optional Feature:
TIMER_SEQ_OVERRUN_EN
- Defined: adds output overrun_cnt[7:0], reset 0. It increments (saturating at 255) on each cfg_start, stop_req or stamp_req that arrives while the same pending flag is already set. Simultaneous merges count as one.
- Undefined: port and logic are absent; merges are silent.

Test Plan:
- Reset, then cfg_start with cfg_period=0x00015F8F -> writes addr2=0x5F8F, addr3=0x0001, addr1=0x0007 on consecutive cycles; busy high for 3 cycles.
- Hold irq high until the addr0 write is seen, then drop it -> exactly one addr0 write with data 0; tick pulses once; tick_count 0->1.
- Same-cycle stamp_req with the slave model returning 0x1234 (addr4) and 0xABCD (addr5) -> addr4 write, then addr4 and addr5 reads; stamp_value=0xABCD1234; stamp_valid one cycle.
- irq and cfg_start in the same cycle -> CLR_ST first, then the WR_PL/WR_PH/WR_CTL sequence; no interleaving.
- stop_req during the stamp sequence -> WR_STOP (addr1, data 0x8) only after CAP_H plus one IDLE cycle.
- TIMER_SEQ_OVERRUN_EN defined: three stamp_req pulses during a busy cfg sequence -> one stamp sequence; overrun_cnt=2. Separately, reset_n low in RD_L -> all outputs return to reset values on the next edge.
